pc_stack_counter: RTL and testbench

Parametrised program counter for the RISC datapath with a hardware return-address stack. It supports increment, absolute load, signed relative branch, call (push and jump) and return (pop). It replaces the plain load/increment PC in the fetch stage and drives the instruction-memory address. Stack overflow and underflow are detected, flagged and latched for the controller.

---
 rtl/pc_stack_counter_if.sv | 29 ++
 rtl/pc_stack_counter.sv | 95 +++++++++
 tb/tb_pc_stack_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pc_stack_counter_if.sv
// Bus between the fetch-stage controller and the program counter with return stack.
interface pc_stack_counter_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic            PC_ENA;
    logic [2:0]      OP;
    logic [SIZE-1:0] DATA;
    logic [SIZE-1:0] OFFSET;
    logic            ERR_CLR;
    logic [SIZE-1:0] COUNT;
    logic [SIZE-1:0] TOS;
    logic [SPW-1:0]  SP;
    logic            STK_FULL;
    logic            STK_EMPTY;
    logic            ERR;

    modport master (
        output PC_ENA, OP, DATA, OFFSET, ERR_CLR,
        input  COUNT, TOS, SP, STK_FULL, STK_EMPTY, ERR
    );

    modport slave (
        input  PC_ENA, OP, DATA, OFFSET, ERR_CLR,
        output COUNT, TOS, SP, STK_FULL, STK_EMPTY, ERR
    );
endinterface

// File: rtl/pc_stack_counter.sv
// Program counter with increment/load/relative branch and a hardware
// return-address stack; overflow and underflow latch a sticky ERR.
module pc_stack_counter #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int STEP  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    pc_stack_counter_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [SIZE-1:0] count, count_nxt;
    logic [SIZE-1:0] stack [DEPTH];
    logic [SPW-1:0]  sp, sp_nxt;
    logic            err, err_nxt;
    logic            push, err_event;
    logic            full, empty;
    logic [IW-1:0]   push_idx, top_idx;
    logic [SIZE-1:0] ret_addr;

    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign push_idx = IW'(sp);
    assign top_idx  = IW'(sp - SPW'(1));
    assign ret_addr = count + SIZE'(STEP);

    always_comb begin
        count_nxt = count;
        sp_nxt    = sp;
        push      = 1'b0;
        err_event = 1'b0;
        if (bus.PC_ENA) begin
            case (bus.OP)
                OP_INC:    count_nxt = count + SIZE'(STEP);
                OP_LOAD:   count_nxt = bus.DATA;
                // modulo-2^SIZE add is identical for signed and unsigned offsets
                OP_BRANCH: count_nxt = count + bus.OFFSET;
                OP_CALL: begin
                    if (full) begin
                        err_event = 1'b1;
                    end else begin
                        push      = 1'b1;
                        sp_nxt    = sp + SPW'(1);
                        count_nxt = bus.DATA;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_event = 1'b1;
                    end else begin
                        sp_nxt    = sp - SPW'(1);
                        count_nxt = stack[top_idx];
                    end
                end
                default: ;
            endcase
        end
        // a same-cycle error event outranks the clear
        err_nxt = (err & ~bus.ERR_CLR) | err_event;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            sp    <= '0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            sp    <= sp_nxt;
            err   <= err_nxt;
            if (push) begin
                stack[push_idx] <= ret_addr;
            end
        end
    end

    assign bus.COUNT     = count;
    assign bus.SP        = sp;
    assign bus.ERR       = err;
    assign bus.STK_FULL  = full;
    assign bus.STK_EMPTY = empty;
    assign bus.TOS       = empty ? '0 : stack[top_idx];
endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed test-plan steps followed by random operations, all checked against
// a queue-based reference model of the PC and its return stack.
module tb_pc_stack_counter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int   m_count = 0;
    int   m_stack[$];
    bit   m_err = 1'b0;

    pc_stack_counter_if #(.SIZE(8), .DEPTH(4)) bus ();

    pc_stack_counter #(.SIZE(8), .DEPTH(4), .STEP(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ena, input int op,
                              input int data, input int offset, input bit clr);
        bit ev = 1'b0;
        if (rst) begin
            m_count = 0;
            m_stack.delete();
            m_err = 1'b0;
            return;
        end
        if (ena) begin
            case (op)
                0: m_count = (m_count + 1) % 256;
                1: m_count = data;
                2: m_count = (m_count + offset) % 256;
                3: if (m_stack.size() < 4) begin
                       m_stack.push_back((m_count + 1) % 256);
                       m_count = data;
                   end else ev = 1'b1;
                4: if (m_stack.size() > 0) m_count = m_stack.pop_back();
                   else ev = 1'b1;
                default: ;
            endcase
        end
        if (clr) m_err = 1'b0;
        if (ev) m_err = 1'b1;
    endtask

    task automatic cyc(input bit rst, input bit ena, input int op,
                       input int data = 0, input int offset = 0, input bit clr = 1'b0);
        int tos;
        RST         = rst;
        bus.PC_ENA  = ena;
        bus.OP      = 3'(op);
        bus.DATA    = 8'(data);
        bus.OFFSET  = 8'(offset);
        bus.ERR_CLR = clr;
        @(posedge CLK);
        model_step(rst, ena, op, data, offset, clr);
        #1;
        tos = (m_stack.size() > 0) ? m_stack[$] : 0;
        chk("count", 32'(bus.COUNT), 32'(m_count));
        chk("sp", 32'(bus.SP), 32'(m_stack.size()));
        chk("tos", 32'(bus.TOS), 32'(tos));
        chk("full", 32'(bus.STK_FULL), 32'(m_stack.size() == 4));
        chk("empty", 32'(bus.STK_EMPTY), 32'(m_stack.size() == 0));
        chk("err", 32'(bus.ERR), 32'(m_err));
    endtask

    initial begin
        bus.PC_ENA = 1'b0; bus.OP = 3'd0; bus.DATA = '0; bus.OFFSET = '0; bus.ERR_CLR = 1'b0;

        // reset and increment
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("rst_count", 32'(bus.COUNT), 32'h0);
        chk("rst_empty", 32'(bus.STK_EMPTY), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0);
            chk("inc_count", 32'(bus.COUNT), 32'(i));
        end
        chk("inc_err", 32'(bus.ERR), 32'h0);

        // wrap and branch
        cyc(0, 1, 1, 'hFE);
        chk("load_fe", 32'(bus.COUNT), 32'hFE);
        cyc(0, 1, 0);
        chk("inc_ff", 32'(bus.COUNT), 32'hFF);
        cyc(0, 1, 0);
        chk("wrap_00", 32'(bus.COUNT), 32'h00);
        cyc(0, 1, 1, 'h10);
        cyc(0, 1, 2, 0, 'hFC);
        chk("branch_back", 32'(bus.COUNT), 32'h0C);

        // nested call / return
        cyc(0, 1, 1, 'h20);
        cyc(0, 1, 3, 'h40);
        cyc(0, 1, 3, 'h60);
        chk("call2_sp", 32'(bus.SP), 32'h2);
        chk("call2_tos", 32'(bus.TOS), 32'h41);
        cyc(0, 1, 4);
        chk("ret1_count", 32'(bus.COUNT), 32'h41);
        chk("ret1_tos", 32'(bus.TOS), 32'h21);
        cyc(0, 1, 4);
        chk("ret2_count", 32'(bus.COUNT), 32'h21);
        chk("ret2_tos", 32'(bus.TOS), 32'h0);

        // overflow
        for (int i = 1; i <= 4; i++) cyc(0, 1, 3, 16 * i);
        chk("full_flag", 32'(bus.STK_FULL), 32'h1);
        cyc(0, 1, 3, 'h80);
        chk("ovf_count", 32'(bus.COUNT), 32'h40);
        chk("ovf_sp", 32'(bus.SP), 32'h4);
        chk("ovf_err", 32'(bus.ERR), 32'h1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("err_sticky", 32'(bus.ERR), 32'h1);
        cyc(0, 1, 5, 0, 0, 1);
        chk("err_clr", 32'(bus.ERR), 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 4);

        // underflow, enable, clear priority
        cyc(0, 1, 1, 'h33);
        cyc(0, 1, 4);
        chk("unf_count", 32'(bus.COUNT), 32'h33);
        chk("unf_err", 32'(bus.ERR), 32'h1);
        cyc(0, 0, 0);
        chk("ena_hold", 32'(bus.COUNT), 32'h33);
        cyc(0, 1, 4, 0, 0, 1);
        chk("clr_vs_set", 32'(bus.ERR), 32'h1);

        // reset during nested calls
        for (int i = 0; i < 3; i++) cyc(0, 1, 3, 'h50 + i);
        chk("pre_rst_sp", 32'(bus.SP), 32'h3);
        cyc(1, 1, 3, 'h99);
        chk("mid_rst_count", 32'(bus.COUNT), 32'h0);
        chk("mid_rst_sp", 32'(bus.SP), 32'h0);
        chk("mid_rst_err", 32'(bus.ERR), 32'h0);
        chk("mid_rst_tos", 32'(bus.TOS), 32'h0);
        cyc(0, 1, 4);
        chk("post_rst_unf", 32'(bus.ERR), 32'h1);

        // random mix
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
